mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS-subset datapath, replacing the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/DIV/MEM/WB states, handshakes with instruction memory, data memory and an iterative divider, and drives the same datapath select codes as the single-cycle controller. It sits between the IR/PC registers and the datapath muxes, and adds a retire counter and an illegal-instruction flag.

---
 rtl/ctrl_pkg.sv | 107 ++++++++++
 rtl/mc_ctrl_if.sv | 41 ++++
 rtl/inst_decode.sv | 36 +++
 rtl/mc_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the MIPS-subset controllers: FSM states, instruction
// types, datapath select codes and the per-type datapath select table.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StDiv    = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  typedef enum logic [10:0] {
    TypeReserved = 11'h000,
    TypeLui      = 11'h001,
    TypeAddiu    = 11'h002,
    TypeLw       = 11'h003,
    TypeSw       = 11'h004,
    TypeBeq      = 11'h005,
    TypeJ        = 11'h006,
    TypeOri      = 11'h007,
    TypeDivu     = 11'h008,
    TypeAdd      = 11'h009,
    TypeSub      = 11'h00A,
    TypeAddu     = 11'h00B,
    TypeSrl      = 11'h00C,
    TypeSll      = 11'h00D
  } inst_type_e;

  // Primary opcodes (IR[31:26]) and R-type function codes (IR[5:0])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnDivu = 6'h1B;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;

  localparam logic [3:0] AluDirect1 = 4'h0;
  localparam logic [3:0] AluAdd     = 4'h1;
  localparam logic [3:0] AluAddu    = 4'h2;
  localparam logic [3:0] AluSub     = 4'h3;
  localparam logic [3:0] AluOr      = 4'h4;
  localparam logic [3:0] AluSll     = 4'h5;
  localparam logic [3:0] AluSrl     = 4'h6;
  localparam logic [3:0] AluLui     = 4'h7;

  localparam logic [1:0] Alu1Rs = 2'd0;
  localparam logic [1:0] Alu1Rt = 2'd1;

  localparam logic [1:0] Alu2Rt    = 2'd0;
  localparam logic [1:0] Alu2Simm  = 2'd1;
  localparam logic [1:0] Alu2Zimm  = 2'd2;
  localparam logic [1:0] Alu2Shamt = 2'd3;

  localparam logic RegWaRt   = 1'b0;
  localparam logic RegWaRd   = 1'b1;
  localparam logic RegWdAlu  = 1'b0;
  localparam logic RegWdDmem = 1'b1;

  localparam logic [3:0] CbNojump = 4'h0;
  localparam logic [3:0] CbBeq    = 4'h1;
  localparam logic [3:0] CbJ      = 4'h2;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alu1_sel;
    logic [1:0] alu2_sel;
    logic       mwa_sel;
    logic       mwd_sel;
  } dp_sel_t;

  function automatic dp_sel_t dp_sel(inst_type_e t);
    dp_sel_t s;
    s = '{alu_op: AluDirect1, alu1_sel: Alu1Rs, alu2_sel: Alu2Rt,
          mwa_sel: RegWaRt, mwd_sel: RegWdAlu};
    case (t)
      TypeLui:   begin s.alu_op = AluLui;  s.alu2_sel = Alu2Zimm; end
      TypeAddiu: begin s.alu_op = AluAddu; s.alu2_sel = Alu2Simm; end
      TypeLw:    begin s.alu_op = AluAdd;  s.alu2_sel = Alu2Simm; s.mwd_sel = RegWdDmem; end
      TypeSw:    begin s.alu_op = AluAdd;  s.alu2_sel = Alu2Simm; end
      TypeBeq:   s.alu_op = AluSub;
      TypeOri:   begin s.alu_op = AluOr;   s.alu2_sel = Alu2Zimm; end
      TypeAdd:   begin s.alu_op = AluAdd;  s.mwa_sel = RegWaRd; end
      TypeSub:   begin s.alu_op = AluSub;  s.mwa_sel = RegWaRd; end
      TypeAddu:  begin s.alu_op = AluAddu; s.mwa_sel = RegWaRd; end
      TypeSrl: begin
        s.alu_op = AluSrl; s.alu1_sel = Alu1Rt; s.alu2_sel = Alu2Shamt; s.mwa_sel = RegWaRd;
      end
      TypeSll: begin
        s.alu_op = AluSll; s.alu1_sel = Alu1Rt; s.alu2_sel = Alu2Shamt; s.mwa_sel = RegWaRd;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Handshake and datapath-select bundle between mc_ctrl and the datapath/memories.
interface mc_ctrl_if #(
  parameter int unsigned ALU_SEL_WIDTH = 4,
  parameter int unsigned CNT_WIDTH     = 32
);
  logic [5:0]               opcode;
  logic [5:0]               func;
  logic                     zero;
  logic                     imem_rdy;
  logic                     dmem_rdy;
  logic                     div_done;

  logic                     imem_re;
  logic                     ir_we;
  logic                     pc_we;
  logic [3:0]               cb;
  logic                     dmem_re;
  logic                     dmem_we;
  logic                     reg_we;
  logic                     mwa_sel;
  logic                     mwd_sel;
  logic [ALU_SEL_WIDTH-1:0] alu_sel;
  logic [1:0]               alu1_sel;
  logic [1:0]               alu2_sel;
  logic                     div_start;
  logic                     illegal;
  logic [CNT_WIDTH-1:0]     retired;
  logic [2:0]               state;

  modport master (
    input  opcode, func, zero, imem_rdy, dmem_rdy, div_done,
    output imem_re, ir_we, pc_we, cb, dmem_re, dmem_we, reg_we, mwa_sel, mwd_sel,
           alu_sel, alu1_sel, alu2_sel, div_start, illegal, retired, state
  );

  modport slave (
    output opcode, func, zero, imem_rdy, dmem_rdy, div_done,
    input  imem_re, ir_we, pc_we, cb, dmem_re, dmem_we, reg_we, mwa_sel, mwd_sel,
           alu_sel, alu1_sel, alu2_sel, div_start, illegal, retired, state
  );
endinterface

// File: rtl/inst_decode.sv
// Combinational opcode/func to instruction-type classifier; unknown encodings
// map to TypeReserved.
module inst_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output inst_type_e inst_type_o
);

  always_comb begin
    inst_type_o = TypeReserved;
    case (opcode_i)
      OpRtype: begin
        case (func_i)
          FnSll:   inst_type_o = TypeSll;
          FnSrl:   inst_type_o = TypeSrl;
          FnDivu:  inst_type_o = TypeDivu;
          FnAdd:   inst_type_o = TypeAdd;
          FnAddu:  inst_type_o = TypeAddu;
          FnSub:   inst_type_o = TypeSub;
          default: inst_type_o = TypeReserved;
        endcase
      end
      OpJ:     inst_type_o = TypeJ;
      OpBeq:   inst_type_o = TypeBeq;
      OpAddiu: inst_type_o = TypeAddiu;
      OpOri:   inst_type_o = TypeOri;
      OpLui:   inst_type_o = TypeLui;
      OpLw:    inst_type_o = TypeLw;
      OpSw:    inst_type_o = TypeSw;
      default: inst_type_o = TypeReserved;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/DIV/MEM/WB, handshakes
// with memories and the divider, counts retired instructions.
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_SEL_WIDTH = 4,
  parameter int unsigned DIV_TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  localparam int unsigned TmoWidth = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;

  state_e               state_q, state_d;
  inst_type_e           type_q, type_dec;
  logic [TmoWidth-1:0]  tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 tmo_hit;
  logic                 retire;
  dp_sel_t              sel;

  logic       imem_re, ir_we, pc_we, dmem_re, dmem_we, reg_we;
  logic       mwa_sel, mwd_sel, div_start, illegal;
  logic [3:0] cb, alu_op;
  logic [1:0] alu1_sel, alu2_sel;

  inst_decode u_inst_decode (
    .opcode_i    (bus.opcode),
    .func_i      (bus.func),
    .inst_type_o (type_dec)
  );

  assign sel     = dp_sel(type_q);
  assign tmo_hit = (tmo_q == TmoWidth'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      type_q    <= TypeReserved;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (state_q == StDecode) type_q <= type_dec;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    retire    = 1'b0;
    imem_re   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    cb        = CbNojump;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    mwa_sel   = 1'b0;
    mwd_sel   = 1'b0;
    alu_op    = AluDirect1;
    alu1_sel  = 2'd0;
    alu2_sel  = 2'd0;
    div_start = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_re = 1'b1;
        if (bus.imem_rdy) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      // Act on the live decode here; type_q only becomes valid after this cycle.
      StDecode: begin
        case (type_dec)
          TypeJ: begin
            cb      = CbJ;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end
          TypeDivu: begin
            div_start = 1'b1;
            tmo_d     = '0;
            state_d   = StDiv;
          end
          TypeReserved: begin
            illegal = 1'b1;
            pc_we   = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        alu_op   = sel.alu_op;
        alu1_sel = sel.alu1_sel;
        alu2_sel = sel.alu2_sel;
        case (type_q)
          TypeBeq: begin
            cb      = bus.zero ? CbBeq : CbNojump;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end
          TypeLw, TypeSw: state_d = StMem;
          TypeLui, TypeAddiu, TypeOri, TypeAdd, TypeSub, TypeAddu, TypeSrl, TypeSll:
            state_d = StWb;
          default: state_d = StFetch;
        endcase
      end
      // div_done wins over an expiring timeout in the same cycle.
      StDiv: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.div_done) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (tmo_hit) begin
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = StFetch;
        end
      end
      StMem: begin
        alu_op   = sel.alu_op;
        alu1_sel = sel.alu1_sel;
        alu2_sel = sel.alu2_sel;
        if (type_q == TypeSw) begin
          dmem_we = 1'b1;
          if (bus.dmem_rdy) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else if (type_q == TypeLw) begin
          dmem_re = 1'b1;
          if (bus.dmem_rdy) state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StWb: begin
        alu_op   = sel.alu_op;
        alu1_sel = sel.alu1_sel;
        alu2_sel = sel.alu2_sel;
        reg_we   = 1'b1;
        mwa_sel  = sel.mwa_sel;
        mwd_sel  = sel.mwd_sel;
        pc_we    = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (rst) begin
      retire    = 1'b0;
      imem_re   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      cb        = CbNojump;
      dmem_re   = 1'b0;
      dmem_we   = 1'b0;
      reg_we    = 1'b0;
      mwa_sel   = 1'b0;
      mwd_sel   = 1'b0;
      alu_op    = AluDirect1;
      alu1_sel  = 2'd0;
      alu2_sel  = 2'd0;
      div_start = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign bus.imem_re   = imem_re;
  assign bus.ir_we     = ir_we;
  assign bus.pc_we     = pc_we;
  assign bus.cb        = cb;
  assign bus.dmem_re   = dmem_re;
  assign bus.dmem_we   = dmem_we;
  assign bus.reg_we    = reg_we;
  assign bus.mwa_sel   = mwa_sel;
  assign bus.mwd_sel   = mwd_sel;
  assign bus.alu_sel   = ALU_SEL_WIDTH'(alu_op);
  assign bus.alu1_sel  = alu1_sel;
  assign bus.alu2_sel  = alu2_sel;
  assign bus.div_start = div_start;
  assign bus.illegal   = illegal;
  assign bus.retired   = retired_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with DIV_TIMEOUT=8 and a 4-bit retire counter.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [3:0] exp_ret;

  always #5 clk = ~clk;

  mc_ctrl_if #(.ALU_SEL_WIDTH(4), .CNT_WIDTH(4)) bus ();

  mc_ctrl #(.ALU_SEL_WIDTH(4), .DIV_TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.imem_rdy = 1'b1; bus.dmem_rdy = 1'b1; bus.div_done = 1'b1;
    bus.zero = 1'b1; bus.opcode = 6'h3F; bus.func = 6'h00;
    tick(); tick(); #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++;
      $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.imem_re !== 1'b0 || bus.ir_we !== 1'b0 || bus.pc_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: imem_re=%b ir_we=%b pc_we=%b want 0",
                         bus.imem_re, bus.ir_we, bus.pc_we); end
    n_cmp++; if (bus.illegal !== 1'b0 || bus.div_start !== 1'b0) begin n_fail++;
      $display("FAIL reset_illegal: illegal=%b div_start=%b want 0", bus.illegal, bus.div_start); end
    n_cmp++; if (bus.retired !== 4'd0) begin n_fail++;
      $display("FAIL reset_retired: got %0d want 0", bus.retired); end
    n_cmp++; if (bus.cb !== 4'd0 || bus.alu_sel !== 4'd0) begin n_fail++;
      $display("FAIL reset_selects: cb=%0d alu_sel=%0d want 0/0", bus.cb, bus.alu_sel); end
    bus.imem_rdy = 1'b0; bus.div_done = 1'b0; rst = 1'b0; #1;
    n_cmp++; if (bus.imem_re !== 1'b1 || bus.ir_we !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_fetch: imem_re=%b ir_we=%b want 1/0", bus.imem_re, bus.ir_we); end
    exp_ret = 4'd0;
  endtask

  // j with one FETCH wait cycle
  task automatic test_fetch_wait();
    bus.opcode = 6'h02; bus.func = 6'h00; bus.imem_rdy = 1'b0;
    tick();
    n_cmp++; if (bus.state !== 3'd0 || bus.imem_re !== 1'b1) begin n_fail++;
      $display("FAIL fetch_wait: state=%0d imem_re=%b want 0/1", bus.state, bus.imem_re); end
    bus.imem_rdy = 1'b1; #1;
    n_cmp++; if (bus.ir_we !== 1'b1) begin n_fail++;
      $display("FAIL fetch_ir_we: got %b want 1", bus.ir_we); end
    tick();
    n_cmp++; if (bus.state !== 3'd1 || bus.pc_we !== 1'b1 || bus.cb !== 4'd2) begin n_fail++;
      $display("FAIL j_decode: state=%0d pc_we=%b cb=%0d want 1/1/2", bus.state, bus.pc_we, bus.cb); end
    tick(); exp_ret++;
    n_cmp++; if (bus.retired !== exp_ret || bus.state !== 3'd0) begin n_fail++;
      $display("FAIL j_retire: retired=%0d state=%0d want %0d/0", bus.retired, bus.state, exp_ret); end
  endtask

  task automatic test_addu();
    bus.opcode = 6'h00; bus.func = 6'h21; bus.imem_rdy = 1'b1; bus.dmem_rdy = 1'b1; #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_fail++;
      $display("FAIL addu_fetch: state=%0d want 0", bus.state); end
    tick();
    n_cmp++; if (bus.state !== 3'd1 || bus.pc_we !== 1'b0) begin n_fail++;
      $display("FAIL addu_decode: state=%0d pc_we=%b want 1/0", bus.state, bus.pc_we); end
    tick();
    n_cmp++; if (bus.state !== 3'd2 || bus.alu_sel !== 4'd2 || bus.alu2_sel !== 2'd0) begin
      n_fail++; $display("FAIL addu_exec: state=%0d alu_sel=%0d alu2_sel=%0d want 2/2/0",
                         bus.state, bus.alu_sel, bus.alu2_sel); end
    tick();
    n_cmp++; if (bus.state !== 3'd5 || bus.reg_we !== 1'b1 || bus.mwa_sel !== 1'b1
                 || bus.mwd_sel !== 1'b0 || bus.pc_we !== 1'b1) begin n_fail++;
      $display("FAIL addu_wb: state=%0d reg_we=%b mwa=%b mwd=%b pc_we=%b want 5/1/1/0/1",
               bus.state, bus.reg_we, bus.mwa_sel, bus.mwd_sel, bus.pc_we); end
    n_cmp++; if (bus.retired !== exp_ret) begin n_fail++;
      $display("FAIL addu_pre_retire: got %0d want %0d", bus.retired, exp_ret); end
    tick(); exp_ret++;
    n_cmp++; if (bus.retired !== exp_ret || bus.state !== 3'd0) begin n_fail++;
      $display("FAIL addu_retire: retired=%0d state=%0d want %0d/0", bus.retired, bus.state, exp_ret); end
  endtask

  task automatic test_lw_wait();
    int cycles = 0;
    int re_cnt = 0;
    bus.opcode = 6'h23; bus.func = 6'h00; bus.imem_rdy = 1'b1; bus.dmem_rdy = 1'b0;
    tick(); cycles++;
    tick(); cycles++;
    n_cmp++; if (bus.alu_sel !== 4'd1 || bus.alu2_sel !== 2'd1) begin n_fail++;
      $display("FAIL lw_exec: alu_sel=%0d alu2_sel=%0d want 1/1", bus.alu_sel, bus.alu2_sel); end
    tick(); cycles++;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.dmem_rdy = 1'b1;
      #1;
      n_cmp++; if (bus.state !== 3'd4) begin n_fail++;
        $display("FAIL lw_mem_state[%0d]: got %0d want 4", i, bus.state); end
      if (bus.dmem_re === 1'b1) re_cnt++;
      tick(); cycles++;
    end
    n_cmp++; if (re_cnt != 4) begin n_fail++;
      $display("FAIL lw_dmem_re_cycles: got %0d want 4", re_cnt); end
    n_cmp++; if (bus.state !== 3'd5 || bus.mwd_sel !== 1'b1 || bus.mwa_sel !== 1'b0
                 || bus.reg_we !== 1'b1 || bus.dmem_re !== 1'b0) begin n_fail++;
      $display("FAIL lw_wb: state=%0d mwd=%b mwa=%b reg_we=%b dmem_re=%b want 5/1/0/1/0",
               bus.state, bus.mwd_sel, bus.mwa_sel, bus.reg_we, bus.dmem_re); end
    tick(); cycles++; exp_ret++;
    n_cmp++; if (cycles != 8 || bus.retired !== exp_ret) begin n_fail++;
      $display("FAIL lw_latency: cycles=%0d retired=%0d want 8/%0d", cycles, bus.retired, exp_ret); end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      bus.opcode = 6'h04; bus.func = 6'h00; bus.zero = z[0];
      tick(); tick();
      n_cmp++; if (bus.state !== 3'd2 || bus.pc_we !== 1'b1
                   || bus.cb !== (z == 1 ? 4'd1 : 4'd0)) begin n_fail++;
        $display("FAIL beq_exec_zero%0d: state=%0d pc_we=%b cb=%0d want 2/1/%0d",
                 z, bus.state, bus.pc_we, bus.cb, (z == 1) ? 1 : 0); end
      tick(); exp_ret++;
      n_cmp++; if (bus.retired !== exp_ret || bus.state !== 3'd0) begin n_fail++;
        $display("FAIL beq_retire_zero%0d: retired=%0d state=%0d want %0d/0",
                 z, bus.retired, bus.state, exp_ret); end
    end
  endtask

  task automatic test_divu_done();
    int ds_cnt = 0;
    bus.opcode = 6'h00; bus.func = 6'h1B; bus.div_done = 1'b0;
    tick();
    n_cmp++; if (bus.state !== 3'd1 || bus.div_start !== 1'b1) begin n_fail++;
      $display("FAIL divu_start: state=%0d div_start=%b want 1/1", bus.state, bus.div_start); end
    if (bus.div_start === 1'b1) ds_cnt++;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.div_done = 1'b1;
      #1;
      if (bus.div_start === 1'b1) ds_cnt++;
      n_cmp++; if (bus.state !== 3'd3 || bus.illegal !== 1'b0
                   || bus.pc_we !== (i == 4) || bus.reg_we !== 1'b0) begin n_fail++;
        $display("FAIL divu_wait[%0d]: state=%0d illegal=%b pc_we=%b reg_we=%b want 3/0/%0d/0",
                 i, bus.state, bus.illegal, bus.pc_we, bus.reg_we, (i == 4) ? 1 : 0); end
      tick();
    end
    bus.div_done = 1'b0; exp_ret++;
    n_cmp++; if (ds_cnt != 1) begin n_fail++;
      $display("FAIL divu_start_pulses: got %0d want 1", ds_cnt); end
    n_cmp++; if (bus.retired !== exp_ret || bus.state !== 3'd0) begin n_fail++;
      $display("FAIL divu_retire: retired=%0d state=%0d want %0d/0", bus.retired, bus.state, exp_ret); end
  endtask

  task automatic test_divu_timeout();
    int il_cnt = 0;
    int il_at = -1;
    bus.opcode = 6'h00; bus.func = 6'h1B; bus.div_done = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bus.state !== 3'd3 || bus.pc_we !== (i == 7)) begin n_fail++;
        $display("FAIL div_tmo_cycle[%0d]: state=%0d pc_we=%b want 3/%0d",
                 i, bus.state, bus.pc_we, (i == 7) ? 1 : 0); end
      if (bus.illegal === 1'b1) begin il_cnt++; il_at = i; end
      tick();
    end
    n_cmp++; if (il_cnt != 1 || il_at != 7) begin n_fail++;
      $display("FAIL div_tmo_illegal: pulses=%0d at=%0d want 1 at 7", il_cnt, il_at); end
    n_cmp++; if (bus.retired !== exp_ret || bus.state !== 3'd0) begin n_fail++;
      $display("FAIL div_tmo_no_retire: retired=%0d state=%0d want %0d/0",
               bus.retired, bus.state, exp_ret); end
  endtask

  task automatic test_illegal();
    bus.opcode = 6'h3F; bus.func = 6'h00;
    tick();
    n_cmp++; if (bus.state !== 3'd1 || bus.illegal !== 1'b1 || bus.pc_we !== 1'b1
                 || bus.cb !== 4'd0) begin n_fail++;
      $display("FAIL illegal_decode: state=%0d illegal=%b pc_we=%b cb=%0d want 1/1/1/0",
               bus.state, bus.illegal, bus.pc_we, bus.cb); end
    tick();
    n_cmp++; if (bus.state !== 3'd0 || bus.illegal !== 1'b0 || bus.retired !== exp_ret) begin
      n_fail++; $display("FAIL illegal_after: state=%0d illegal=%b retired=%0d want 0/0/%0d",
                         bus.state, bus.illegal, bus.retired, exp_ret); end
  endtask

  task automatic test_sw();
    bus.opcode = 6'h2B; bus.func = 6'h00; bus.dmem_rdy = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (bus.state !== 3'd4 || bus.dmem_we !== 1'b1 || bus.pc_we !== 1'b1
                 || bus.reg_we !== 1'b0) begin n_fail++;
      $display("FAIL sw_mem: state=%0d dmem_we=%b pc_we=%b reg_we=%b want 4/1/1/0",
               bus.state, bus.dmem_we, bus.pc_we, bus.reg_we); end
    tick(); exp_ret++;
    n_cmp++; if (bus.retired !== exp_ret || bus.state !== 3'd0) begin n_fail++;
      $display("FAIL sw_retire: retired=%0d state=%0d want %0d/0", bus.retired, bus.state, exp_ret); end
  endtask

  task automatic test_reset_mid_sw();
    bus.opcode = 6'h2B; bus.func = 6'h00; bus.dmem_rdy = 1'b0;
    tick(); tick(); tick(); tick();
    n_cmp++; if (bus.state !== 3'd4 || bus.dmem_we !== 1'b1 || bus.pc_we !== 1'b0) begin
      n_fail++; $display("FAIL sw_hold: state=%0d dmem_we=%b pc_we=%b want 4/1/0",
                         bus.state, bus.dmem_we, bus.pc_we); end
    rst = 1'b1; #1;
    n_cmp++; if (bus.dmem_we !== 1'b0) begin n_fail++;
      $display("FAIL rst_forces_dmem_we: got %b want 0", bus.dmem_we); end
    tick();
    exp_ret = 4'd0;
    n_cmp++; if (bus.state !== 3'd0 || bus.dmem_we !== 1'b0 || bus.retired !== exp_ret) begin
      n_fail++; $display("FAIL rst_mid_sw: state=%0d dmem_we=%b retired=%0d want 0/0/0",
                         bus.state, bus.dmem_we, bus.retired); end
    rst = 1'b0; #1;
    n_cmp++; if (bus.imem_re !== 1'b1) begin n_fail++;
      $display("FAIL rst_release_fetch: imem_re=%b want 1", bus.imem_re); end
  endtask

  task automatic test_j_wrap();
    for (int k = 0; k < 16; k++) begin
      bus.opcode = 6'h02; bus.func = 6'h00; bus.imem_rdy = 1'b1;
      tick();
      n_cmp++; if (bus.pc_we !== 1'b1 || bus.cb !== 4'd2) begin n_fail++;
        $display("FAIL j_wrap_decode[%0d]: pc_we=%b cb=%0d want 1/2", k, bus.pc_we, bus.cb); end
      tick(); exp_ret++;
      n_cmp++; if (bus.retired !== exp_ret) begin n_fail++;
        $display("FAIL j_wrap_count[%0d]: got %0d want %0d", k, bus.retired, exp_ret); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_addu();
    test_lw_wait();
    test_beq();
    test_divu_done();
    test_divu_timeout();
    test_illegal();
    test_sw();
    test_reset_mid_sw();
    test_j_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
